// File: rtl/alu_serial_pkg.sv
// Shared encodings and FSM state type for the bit-serial ALU controller.
// Optional zero flag is enabled by defining ALU_SERIAL_ZERO_FLAG_EN.
package alu_serial_pkg;

   // op = {binv, sel1, sel0}
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   localparam logic [1:0] SEL_AND = 2'b00;
   localparam logic [1:0] SEL_OR  = 2'b01;
   localparam logic [1:0] SEL_ADD = 2'b10;
   localparam logic [1:0] SEL_SLT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_serial_slice.sv
// Combinational one-bit ALU slice: b inversion, AND/OR, full adder, 4:1 select.
// The set output is the raw sum bit, used by SLT when this slice sees the MSB.
module alu_serial_slice
   import alu_serial_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   input  logic       binv_i,
   input  logic       carry_i,
   input  logic       less_i,
   input  logic [1:0] sel_i,
   output logic       res_o,
   output logic       carry_o,
   output logic       set_o
);

   logic bmux;
   logic sum;

   always_comb begin
      bmux    = b_i ^ binv_i;
      sum     = a_i ^ bmux ^ carry_i;
      carry_o = (a_i & bmux) | (a_i & carry_i) | (bmux & carry_i);
      set_o   = sum;
      res_o   = 1'b0;
      unique case (sel_i)
         SEL_AND: res_o = a_i & bmux;
         SEL_OR:  res_o = a_i | bmux;
         SEL_ADD: res_o = sum;
         SEL_SLT: res_o = less_i;
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: IDLE -> RUN (WIDTH cycles, LSB first) -> DONE -> IDLE.
// Define ALU_SERIAL_ZERO_FLAG_EN to add the registered zero output.
module alu_serial_ctrl
   import alu_serial_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             overflow
`ifdef ALU_SERIAL_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2:0]         op_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q;
   logic [WIDTH-2:0]   res_sh_q;
   logic [WIDTH-1:0]   result_q;
   logic               ovf_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
   logic               zero_q;
`endif

   logic               slice_res, slice_carry, slice_set;
   logic               last_bit;
   logic [WIDTH-1:0]   collected;
   logic [WIDTH-1:0]   final_res;

   alu_serial_slice u_slice (
      .a_i     (a_q[0]),
      .b_i     (b_q[0]),
      .binv_i  (op_q[2]),
      .carry_i (carry_q),
      .less_i  (1'b0),
      .sel_i   (op_q[1:0]),
      .res_o   (slice_res),
      .carry_o (slice_carry),
      .set_o   (slice_set)
   );

   // SLT discards the serial bits and reports only the MSB sum in bit 0
   always_comb begin
      last_bit  = (state_q == ST_RUN) && (cnt_q == CNT_LAST);
      collected = {slice_res, res_sh_q};
      final_res = collected;
      if (op_q[1:0] == SEL_SLT) begin
         final_res = {{(WIDTH-1){1'b0}}, slice_set};
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start)    state_d = ST_RUN;
         ST_RUN:  if (last_bit) state_d = ST_DONE;
         ST_DONE:               state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         res_sh_q <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
         zero_q   <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            cnt_q   <= '0;
            carry_q <= op[2];
         end else if (state_q == ST_RUN) begin
            a_q      <= a_q >> 1;
            b_q      <= b_q >> 1;
            carry_q  <= slice_carry;
            res_sh_q <= collected[WIDTH-1:1];
            cnt_q    <= cnt_q + CNT_W'(1);
            // carry_q is the carry into the MSB on the last cycle
            if (last_bit) begin
               result_q <= final_res;
               ovf_q    <= (op_q[1:0] == SEL_ADD) && (carry_q ^ slice_carry);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
               zero_q   <= (final_res == '0);
`endif
            end
         end
      end
   end

   assign result   = result_q;
   assign overflow = ovf_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
   assign zero     = zero_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed, table-driven bench for alu_serial_ctrl (WIDTH=32), with hand-written
// sequences for ignored start, back-to-back restart and reset mid-operation.
module tb_alu_serial_ctrl;
   import alu_serial_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, overflow;
   logic [W-1:0] result;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
   logic         zero;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         ovf;
      logic         zf;
      string        name;
   } vec_t;

   vec_t vecs[14];

   alu_serial_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .overflow (overflow)
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      ,
      .zero     (zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Presents start for one cycle (optionally re-pulsing it mid-run), scrambles
   // the inputs while busy, and returns edges from start presentation to done.
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input int inject_at, output int edges, output int busy_cyc,
                         output bit got_done);
      @(negedge clk);
      op = o; a = va; b = vb; start = 1'b1;
      edges = 0; busy_cyc = 0; got_done = 1'b0;
      while (edges < 100 && !got_done) begin
         @(negedge clk);
         edges++;
         start = (inject_at != 0 && edges == inject_at);
         a  = $urandom;
         b  = $urandom;
         op = 3'($urandom_range(0, 7));
         if (done) got_done = 1'b1;
         else if (busy) busy_cyc++;
      end
      start = 1'b0;
      if (!got_done) check("done_timeout", 32'(got_done), 32'd1);
   endtask

   initial begin
      int edges, busy_cyc, cnt, d1, d2;
      bit got;

      vecs[0]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, "add_ovf"};
      vecs[1]  = '{OP_SUB, 32'd5,         32'd5,         32'h0000_0000, 1'b0, 1'b1, "sub_eq"};
      vecs[2]  = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, "sub_ovf"};
      vecs[3]  = '{OP_SLT, 32'd3,         32'd7,         32'h0000_0001, 1'b0, 1'b0, "slt_lt"};
      vecs[4]  = '{OP_SLT, 32'd7,         32'd3,         32'h0000_0000, 1'b0, 1'b1, "slt_gt"};
      vecs[5]  = '{OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, "and"};
      vecs[6]  = '{OP_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0, "or"};
      vecs[7]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, "add_wrap"};
      vecs[8]  = '{OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, "add_negovf"};
      vecs[9]  = '{OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_neg"};
      vecs[10] = '{OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, "slt_neg"};
      vecs[11] = '{3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0000, 1'b0, 1'b0, "andn"};
      vecs[12] = '{3'b101, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, "orn"};
      vecs[13] = '{OP_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, "add_plain"};

      // reset state
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      check("rst_zero", 32'(zero), 32'd1);
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, edges, busy_cyc, got);
         if (got) begin
            check({vecs[i].name, "_res"}, result, vecs[i].res);
            check({vecs[i].name, "_ovf"}, 32'(overflow), 32'(vecs[i].ovf));
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            check({vecs[i].name, "_zero"}, 32'(zero), 32'(vecs[i].zf));
`endif
            check({vecs[i].name, "_busy_done"}, 32'(busy), 32'd0);
            if (i == 0) begin
               check("lat_edges", 32'(edges), 32'd33);
               check("busy_cycles", 32'(busy_cyc), 32'd32);
            end
            @(negedge clk);
            check({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
            check({vecs[i].name, "_hold"}, result, vecs[i].res);
         end
      end

      // start pulsed at RUN cycle 5 must be ignored
      run_op(OP_ADD, 32'd100, 32'd23, 5, edges, busy_cyc, got);
      check("ign_res", result, 32'd123);
      check("ign_lat", 32'(edges), 32'd33);
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy || done) cnt++;
      end
      check("ign_no_queue", 32'(cnt), 32'd0);
      check("ign_hold", result, 32'd123);

      // start held high: done pulses 34 cycles apart
      @(negedge clk);
      op = OP_ADD; a = 32'h7FFF_FFFF; b = 32'h0000_0001; start = 1'b1;
      d1 = -1; d2 = -1; cnt = 0;
      while (cnt < 200 && d2 < 0) begin
         @(negedge clk);
         cnt++;
         if (done) begin
            if (d1 < 0) d1 = cnt;
            else d2 = cnt;
         end
      end
      start = 1'b0;
      check("b2b_seen", 32'(d2 >= 0), 32'd1);
      check("b2b_gap", 32'(d2 - d1), 32'd34);
      check("b2b_res", result, 32'h8000_0000);
      check("b2b_ovf", 32'(overflow), 32'd1);
      repeat (3) @(negedge clk);
      check("b2b_stop", 32'(busy), 32'd0);

      // reset at RUN cycle 10 aborts without a done pulse
      @(negedge clk);
      op = OP_ADD; a = 32'd10; b = 32'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", result, 32'd0);
      check("abort_ovf", 32'(overflow), 32'd0);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      check("abort_zero", 32'(zero), 32'd1);
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) cnt++;
      end
      check("abort_no_done", 32'(cnt), 32'd0);
      run_op(OP_ADD, 32'd2, 32'd3, 0, edges, busy_cyc, got);
      check("post_rst_res", result, 32'd5);
      check("post_rst_ovf", 32'(overflow), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
